// File: rtl/branch_seq_decoder.sv
// rtl/branch_seq_decoder.sv - multi-cycle branch sequencer driving the 33-bit control word and PC offset
module branch_seq_decoder #(
    parameter int DATA_WIDTH = 64,
    parameter int LINK_REG   = 30,
    parameter bit COND_EN    = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           I,
    input  logic [4:0]            status,
    input  logic                  alu_zero,
    output logic [32:0]           cw_IW,
    output logic [DATA_WIDTH-1:0] K,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LINK,
        S_TEST,
        S_EXEC
    } state_t;

    typedef enum logic [2:0] {
        OP_B,
        OP_BL,
        OP_BR,
        OP_CBZ,
        OP_CBNZ,
        OP_BCOND,
        OP_ILL
    } op_t;

    localparam logic [4:0] LINK_DA = LINK_REG[4:0];

    state_t      state_q, state_d;
    op_t         op_q, op_dec;
    logic [25:0] instr_q;
    logic        taken_q;

    // Flag bit 4 is reserved and never consulted.
    logic unused_status;
    assign unused_status = status[4];

    always_comb begin
        op_dec = OP_ILL;
        if (I[31:26] == 6'b000101) begin
            op_dec = OP_B;
        end else if (I[31:26] == 6'b100101) begin
            op_dec = OP_BL;
        end else if (I[31:24] == 8'b10110100) begin
            op_dec = OP_CBZ;
        end else if (I[31:24] == 8'b10110101) begin
            op_dec = OP_CBNZ;
        end else if (COND_EN && I[31:24] == 8'b01010100) begin
            op_dec = OP_BCOND;
        end else if (I[31:21] == 11'b11010110000) begin
            op_dec = OP_BR;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op_dec)
                        OP_BL:           state_d = S_LINK;
                        OP_CBZ, OP_CBNZ: state_d = S_TEST;
                        default:         state_d = S_EXEC;
                    endcase
                end
            end
            S_LINK:  state_d = S_EXEC;
            S_TEST:  state_d = S_EXEC;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ILL;
            instr_q <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                op_q    <= op_dec;
                instr_q <= I[25:0];
            end
            if (state_q == S_TEST) begin
                taken_q <= (op_q == OP_CBZ) ? alu_zero : ~alu_zero;
            end
        end
    end

    function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] flags);
        logic z, n, c, v, r;
        z = flags[0];
        n = flags[1];
        c = flags[2];
        v = flags[3];
        case (cond[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c & ~z;
            3'd5:    r = (n == v);
            3'd6:    r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        // Odd codes invert their even partner, except 15 which is still "always".
        if (cond[0] && cond[3:1] != 3'd7) begin
            r = ~r;
        end
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] k_imm26, k_imm19;
    assign k_imm26 = {{(DATA_WIDTH-28){instr_q[25]}}, instr_q[25:0], 2'b00};
    assign k_imm19 = {{(DATA_WIDTH-21){instr_q[23]}}, instr_q[23:5], 2'b00};

    always_comb begin
        K = '0;
        if (state_q != S_IDLE) begin
            case (op_q)
                OP_B, OP_BL:                 K = k_imm26;
                OP_CBZ, OP_CBNZ, OP_BCOND:   K = k_imm19;
                default:                     K = '0;
            endcase
        end
    end

    logic       alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is, status_ld;
    logic [4:0] alu_fs, rf_sa, rf_sb, rf_da;
    logic [1:0] pc_fs, next_st;

    always_comb begin
        alu_en    = 1'b0;
        alu_bs    = 1'b0;
        alu_fs    = 5'b11111;
        rf_b_en   = 1'b0;
        rf_sa     = 5'd31;
        rf_sb     = 5'd31;
        rf_da     = 5'd31;
        rf_w      = 1'b0;
        ram_en    = 1'b0;
        ram_w     = 1'b0;
        pc_en     = 1'b0;
        pc_fs     = 2'b00;
        pc_is     = 1'b0;
        status_ld = 1'b0;
        next_st   = 2'b00;
        done      = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_LINK: begin
                // PC+4 is driven onto the databus and captured as the return address.
                pc_en   = 1'b1;
                rf_da   = LINK_DA;
                rf_w    = 1'b1;
                next_st = 2'b01;
            end
            S_TEST: begin
                rf_sa   = instr_q[4:0];
                alu_fs  = 5'b01000;
                next_st = 2'b01;
            end
            S_EXEC: begin
                done = 1'b1;
                case (op_q)
                    OP_B, OP_BL: pc_fs = 2'b10;
                    OP_BR: begin
                        rf_sa = instr_q[9:5];
                        pc_fs = 2'b11;
                        pc_is = 1'b1;
                    end
                    OP_CBZ, OP_CBNZ: pc_fs = taken_q ? 2'b10 : 2'b01;
                    OP_BCOND: pc_fs = cond_eval(instr_q[3:0], status) ? 2'b10 : 2'b01;
                    default: begin
                        pc_fs   = 2'b01;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    assign cw_IW = {alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w,
                    ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld, next_st};
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_branch_seq_decoder.sv
// tb/tb_branch_seq_decoder.sv - directed self-checking bench for branch_seq_decoder
module tb_branch_seq_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] I;
    logic [4:0]  status;
    logic        alu_zero;
    logic [32:0] cw_IW;
    logic [63:0] K;
    logic        busy, done, illegal;

    int n_chk  = 0;
    int n_pass = 0;

    branch_seq_decoder dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .I        (I),
        .status   (status),
        .alu_zero (alu_zero),
        .cw_IW    (cw_IW),
        .K        (K),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [32:0] cw_of(input logic pc_en, input logic [1:0] pc_fs,
                                          input logic pc_is, input logic [4:0] sa,
                                          input logic [4:0] da, input logic rf_w,
                                          input logic [4:0] alu_fs, input logic [1:0] ns);
        return {1'b0, 1'b0, alu_fs, 1'b0, sa, 5'd31, da, rf_w, 1'b0, 1'b0,
                pc_en, pc_fs, pc_is, 1'b0, ns};
    endfunction

    function automatic logic cond_model(input logic [3:0] cd, input logic [3:0] f);
        logic z, n, c, v;
        z = f[0]; n = f[1]; c = f[2]; v = f[3];
        case (cd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !(c && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    task automatic issue(input logic [31:0] instr);
        I     = instr;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_cb(input bit nz, input logic az, input logic exp_taken);
        string nm;
        nm = nz ? "cbnz" : "cbz";
        issue({7'b1011010, nz, 19'h7FFFE, 5'd3});
        chk({nm, "_test_cw"}, 64'(cw_IW), 64'(cw_of(0, 2'b00, 0, 5'd3, 5'd31, 0, 5'b01000, 2'b01)));
        chk({nm, "_test_done"}, 64'(done), 64'(1'b0));
        alu_zero = az;
        step();
        alu_zero = ~az;
        chk({nm, "_exec_pcfs"}, 64'(cw_IW[5:4]), exp_taken ? 64'd2 : 64'd1);
        chk({nm, "_exec_k"}, K, 64'hFFFF_FFFF_FFFF_FFF8);
        chk({nm, "_exec_done"}, 64'(done), 64'(1'b1));
        step();
    endtask

    localparam logic [32:0] NOP_CW = 33'h0_7DFF_FC00;

    initial begin
        reset = 1'b1; start = 1'b0; I = '0; status = '0; alu_zero = 1'b0;
        step();
        step();
        chk("rst_cw", 64'(cw_IW), 64'(NOP_CW));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_illegal", 64'(illegal), 64'(1'b0));
        chk("rst_k", K, 64'd0);
        reset = 1'b0;
        step();

        // B with offset -1 word
        issue({6'b000101, 26'h3FF_FFFF});
        chk("b_k", K, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("b_cw", 64'(cw_IW), 64'(cw_of(0, 2'b10, 0, 5'd31, 5'd31, 0, 5'h1F, 2'b00)));
        chk("b_done", 64'(done), 64'(1'b1));
        chk("b_busy", 64'(busy), 64'(1'b1));
        step();
        chk("b_idle_busy", 64'(busy), 64'(1'b0));
        chk("b_idle_done", 64'(done), 64'(1'b0));
        chk("b_idle_cw", 64'(cw_IW), 64'(NOP_CW));

        // BL with start held high while busy carrying a different branch
        issue({6'b100101, 26'h10});
        chk("bl_link_cw", 64'(cw_IW), 64'(cw_of(1, 2'b00, 0, 5'd31, 5'd30, 1, 5'h1F, 2'b01)));
        chk("bl_link_done", 64'(done), 64'(1'b0));
        I = {6'b000101, 26'h3FF_FFFF};
        start = 1'b1;
        step();
        start = 1'b0;
        chk("bl_exec_k", K, 64'h40);
        chk("bl_exec_cw", 64'(cw_IW), 64'(cw_of(0, 2'b10, 0, 5'd31, 5'd31, 0, 5'h1F, 2'b00)));
        chk("bl_exec_done", 64'(done), 64'(1'b1));
        step();
        chk("bl_after_busy", 64'(busy), 64'(1'b0));

        do_cb(1'b0, 1'b1, 1'b1);
        do_cb(1'b0, 1'b0, 1'b0);
        do_cb(1'b1, 1'b1, 1'b0);
        do_cb(1'b1, 1'b0, 1'b1);

        // BR X7
        issue({11'b11010110000, 11'h7C0, 5'd7, 5'd0});
        chk("br_cw", 64'(cw_IW), 64'(cw_of(0, 2'b11, 1, 5'd7, 5'd31, 0, 5'h1F, 2'b00)));
        chk("br_k", K, 64'd0);
        chk("br_done", 64'(done), 64'(1'b1));
        step();

        // opcode 0 is illegal
        issue(32'h0);
        chk("ill_cw", 64'(cw_IW), 64'(cw_of(0, 2'b01, 0, 5'd31, 5'd31, 0, 5'h1F, 2'b00)));
        chk("ill_pulse", 64'(illegal), 64'(1'b1));
        chk("ill_done", 64'(done), 64'(1'b1));
        step();
        chk("ill_clear", 64'(illegal), 64'(1'b0));

        // B.cond sweep: every condition against every flag combination
        for (int cd = 0; cd < 16; cd++) begin
            for (int f = 0; f < 16; f++) begin
                logic [3:0] cd4, f4;
                cd4 = 4'(cd);
                f4  = 4'(f);
                status = {1'b0, f4};
                issue({8'b01010100, 19'h5, 1'b0, cd4});
                chk($sformatf("bcond_c%0d_f%0d", cd, f), 64'(cw_IW[5:4]),
                    cond_model(cd4, f4) ? 64'd2 : 64'd1);
                if (cd == 0 && f == 0) begin
                    chk("bcond_k", K, 64'h14);
                    chk("bcond_done", 64'(done), 64'(1'b1));
                end
                step();
            end
        end
        status = '0;

        // reset during the link cycle abandons the write
        issue({6'b100101, 26'h10});
        chk("rl_link_w", 64'(cw_IW[9]), 64'(1'b1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rl_busy", 64'(busy), 64'(1'b0));
        chk("rl_cw", 64'(cw_IW), 64'(NOP_CW));
        chk("rl_done", 64'(done), 64'(1'b0));
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rl_rfw_%0d", c), 64'(cw_IW[9]), 64'(1'b0));
            chk($sformatf("rl_idle_%0d", c), 64'(busy), 64'(1'b0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
